trap_sequencer: RTL and testbench

- Machine-mode trap controller in front of the CSR/trap unit.
- Arbitrates simultaneous exception sources, the external interrupt and mret, then sequences trap entry: stall, LSU drain, single-cycle CSR commit, PC redirect.
- Sits between the execute/LSU stages and the fetch redirect path.
- Guarantees one trap in flight and a fixed priority.

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_prio_enc.sv | 43 ++++
 rtl/trap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    TVAL_ZERO,
    TVAL_PC,
    TVAL_ADDR
  } tval_sel_t;

  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_IMIS   = 32'd0;
  localparam logic [31:0] CAUSE_LMIS   = 32'd4;
  localparam logic [31:0] CAUSE_SMIS   = 32'd6;
  localparam logic [31:0] CAUSE_MEXT   = 32'h8000000B;

  localparam int unsigned EXC_EBREAK = 0;
  localparam int unsigned EXC_ECALL  = 1;
  localparam int unsigned EXC_IMIS   = 2;
  localparam int unsigned EXC_LMIS   = 3;
  localparam int unsigned EXC_SMIS   = 4;
  localparam int unsigned EXC_W      = 5;

  // Grant vector layout: mret, the five exception bits, then the interrupt.
  localparam int unsigned GNT_W    = 7;
  localparam int unsigned GNT_MRET = 0;
  localparam int unsigned GNT_EXC0 = 1;
  localparam int unsigned GNT_IRQ  = 6;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority request encoder: mret > ebreak > ecall > imis > lmis > smis > irq.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic             mret_req,
  input  logic [EXC_W-1:0] exc_valid,
  input  logic             irq_req,
  output logic [GNT_W-1:0] grant,
  output logic [31:0]      cause,
  output tval_sel_t        tval_sel
);

  always_comb begin
    grant    = '0;
    cause    = '0;
    tval_sel = TVAL_ZERO;
    if (mret_req) begin
      grant[GNT_MRET] = 1'b1;
    end else if (exc_valid[EXC_EBREAK]) begin
      grant[GNT_EXC0 + EXC_EBREAK] = 1'b1;
      cause = CAUSE_EBREAK;
    end else if (exc_valid[EXC_ECALL]) begin
      grant[GNT_EXC0 + EXC_ECALL] = 1'b1;
      cause = CAUSE_ECALL;
    end else if (exc_valid[EXC_IMIS]) begin
      grant[GNT_EXC0 + EXC_IMIS] = 1'b1;
      cause    = CAUSE_IMIS;
      tval_sel = TVAL_PC;
    end else if (exc_valid[EXC_LMIS]) begin
      grant[GNT_EXC0 + EXC_LMIS] = 1'b1;
      cause    = CAUSE_LMIS;
      tval_sel = TVAL_ADDR;
    end else if (exc_valid[EXC_SMIS]) begin
      grant[GNT_EXC0 + EXC_SMIS] = 1'b1;
      cause    = CAUSE_SMIS;
      tval_sel = TVAL_ADDR;
    end else if (irq_req) begin
      grant[GNT_IRQ] = 1'b1;
      cause = CAUSE_MEXT;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: stall, LSU drain, CSR commit, redirect.
// Optional: TRAP_VECTORED_EN enables vectored interrupt targets when mtvec_in[1:0]==2'b01.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DRAIN_TIMEOUT = 15,
  parameter int unsigned TMO_W         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_ext,
  input  logic            mie,
  input  logic            mret_req,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            lsu_busy,
  output logic            pipe_stall,
  output logic            pipe_flush,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_mcause,
  output logic [XLEN-1:0] csr_mepc,
  output logic [XLEN-1:0] csr_mtval,
  output logic            mret_done,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_tmo
);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              irq_d_q;
  logic              irq_pend_q, irq_pend_d;
  logic              is_mret_q, is_mret_d;
  logic              tmo_q, tmo_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;

  logic [GNT_W-1:0]  grant;
  logic [31:0]       cause;
  tval_sel_t         tval_sel;
  logic              accept;
  logic [XLEN-1:0]   base;

  trap_prio_enc u_prio (
    .mret_req (mret_req),
    .exc_valid(exc_valid),
    .irq_req  (irq_pend_q & mie),
    .grant    (grant),
    .cause    (cause),
    .tval_sel (tval_sel)
  );

  assign accept = (state_q == IDLE) && !rst && (|grant);
  assign base   = mtvec_in & ~XLEN'(3);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_mret_d      = is_mret_q;
    tmo_d          = tmo_q;
    mcause_d       = mcause_q;
    mepc_d         = mepc_q;
    mtval_d        = mtval_q;
    irq_pend_d     = irq_pend_q | (irq_ext & ~irq_d_q);
    pipe_stall     = 1'b0;
    pipe_flush     = 1'b0;
    csr_we         = 1'b0;
    mret_done      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pipe_stall = 1'b1;
          pipe_flush = 1'b1;
          state_d    = DRAIN;
          cnt_d      = '0;
          is_mret_d  = grant[GNT_MRET];
          // Acceptance clears the pending flag even if a fresh edge arrives now.
          if (grant[GNT_IRQ]) irq_pend_d = 1'b0;
          if (!grant[GNT_MRET]) begin
            mcause_d = XLEN'(cause);
            mepc_d   = grant[GNT_IRQ] ? pc_ex : exc_pc;
            unique case (tval_sel)
              TVAL_PC:   mtval_d = exc_pc;
              TVAL_ADDR: mtval_d = exc_tval;
              default:   mtval_d = '0;
            endcase
          end
        end
      end
      DRAIN: begin
        pipe_stall = 1'b1;
        if (cnt_q != TMO_W'(DRAIN_TIMEOUT)) cnt_d = cnt_q + TMO_W'(1);
        if (is_mret_q || !lsu_busy) begin
          state_d = COMMIT;
        end else if (cnt_q == TMO_W'(DRAIN_TIMEOUT)) begin
          state_d = COMMIT;
          tmo_d   = 1'b1;
        end
      end
      COMMIT: begin
        pipe_stall = 1'b1;
        csr_we     = !is_mret_q;
        mret_done  = is_mret_q;
        state_d    = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        state_d        = IDLE;
        redirect_pc    = is_mret_q ? mepc_in : base;
`ifdef TRAP_VECTORED_EN
        if (!is_mret_q && mcause_q[XLEN-1] && (mtvec_in[1:0] == 2'b01))
          redirect_pc = base + (mcause_q << 2);
`endif
      end
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed during reset so an aborted sequence never commits.
    if (rst) begin
      pipe_stall     = 1'b0;
      pipe_flush     = 1'b0;
      csr_we         = 1'b0;
      mret_done      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      irq_d_q    <= 1'b0;
      irq_pend_q <= 1'b0;
      is_mret_q  <= 1'b0;
      tmo_q      <= 1'b0;
      mcause_q   <= '0;
      mepc_q     <= '0;
      mtval_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_d_q    <= irq_ext;
      irq_pend_q <= irq_pend_d;
      is_mret_q  <= is_mret_d;
      tmo_q      <= tmo_d;
      mcause_q   <= mcause_d;
      mepc_q     <= mepc_d;
      mtval_q    <= mtval_d;
    end
  end

  assign csr_mcause = mcause_q;
  assign csr_mepc   = mepc_q;
  assign csr_mtval  = mtval_q;
  assign drain_tmo  = tmo_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random traffic vs a timestamp model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  exc_valid;
  logic [31:0] exc_pc, exc_tval, pc_ex, mtvec_in, mepc_in;
  logic        irq_ext, mie, mret_req, lsu_busy;
  logic        pipe_stall, pipe_flush, csr_we, mret_done, redirect_valid, drain_tmo;
  logic [31:0] csr_mcause, csr_mepc, csr_mtval, redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  trap_sequencer #(.XLEN(32), .DRAIN_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .irq_ext(irq_ext), .mie(mie), .mret_req(mret_req), .pc_ex(pc_ex),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in), .lsu_busy(lsu_busy),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush), .csr_we(csr_we),
    .csr_mcause(csr_mcause), .csr_mepc(csr_mepc), .csr_mtval(csr_mtval),
    .mret_done(mret_done), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_tmo(drain_tmo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a trap in flight is described by its acceptance cycle and,
  // once the drain resolves, the cycle in which the CSR commit happens.
  localparam int TIMEOUT = 15;
  logic [31:0] cause_tab [5] = '{32'd3, 32'd11, 32'd0, 32'd4, 32'd6};
  int          cyc = 0;
  bit          m_busy, m_mret, m_irq, m_pend, m_irqd, m_tmo;
  int          m_acc, m_commit;
  logic [31:0] m_cause, m_mepc, m_mtval;

  function automatic bit want_accept();
    return !rst && !m_busy && (mret_req || (exc_valid != 5'd0) || (m_pend && mie));
  endfunction

  task automatic check_outputs();
    bit acc, draining, commit, redir;
    logic [31:0] exp_pc;
    acc      = want_accept();
    draining = m_busy && (m_commit < 0);
    commit   = !rst && m_busy && (cyc == m_commit);
    redir    = !rst && m_busy && (m_commit >= 0) && (cyc == m_commit + 1);
    check_eq("pipe_stall", 32'(pipe_stall), 32'(acc || (!rst && draining) || commit));
    check_eq("pipe_flush", 32'(pipe_flush), 32'(acc));
    check_eq("csr_we", 32'(csr_we), 32'(commit && !m_mret));
    check_eq("mret_done", 32'(mret_done), 32'(commit && m_mret));
    check_eq("redirect_valid", 32'(redirect_valid), 32'(redir));
    check_eq("drain_tmo", 32'(drain_tmo), 32'(m_tmo));
    if (commit && !m_mret) begin
      check_eq("mcause", csr_mcause, m_cause);
      check_eq("mepc", csr_mepc, m_mepc);
      check_eq("mtval", csr_mtval, m_mtval);
    end
    if (redir) begin
      exp_pc = m_mret ? mepc_in : {mtvec_in[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if (!m_mret && m_irq && mtvec_in[1:0] == 2'b01) exp_pc = {mtvec_in[31:2], 2'b00} + 32'd44;
`endif
      check_eq("redirect_pc", redirect_pc, exp_pc);
    end
  endtask

  task automatic model_step();
    bit edge_seen, irq_taken;
    edge_seen = irq_ext && !m_irqd;
    irq_taken = 1'b0;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_irqd = 0; m_tmo = 0; m_mret = 0;
      m_cause = '0; m_mepc = '0; m_mtval = '0;
    end else begin
      if (!m_busy) begin
        if (want_accept()) begin
          m_busy = 1; m_acc = cyc; m_commit = -1; m_mret = 0; m_irq = 0;
          if (mret_req) m_mret = 1;
          else if (exc_valid != 5'd0) begin
            for (int b = 4; b >= 0; b--) if (exc_valid[b]) begin
              m_cause = cause_tab[b];
              m_mtval = (b == 2) ? exc_pc : (b >= 3) ? exc_tval : 32'd0;
            end
            m_mepc = exc_pc;
          end else begin
            m_irq = 1; irq_taken = 1;
            m_cause = 32'h8000000B; m_mepc = pc_ex; m_mtval = 32'd0;
          end
        end
      end else if (m_commit < 0) begin
        if (m_mret || !lsu_busy) m_commit = cyc + 1;
        else if (cyc - m_acc - 1 >= TIMEOUT) begin
          m_commit = cyc + 1;
          m_tmo = 1;
        end
      end else if (cyc == m_commit + 1) begin
        m_busy = 0;
      end
      m_pend = (m_pend || edge_seen) && !irq_taken;
      m_irqd = irq_ext;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic quiet();
    exc_valid = '0; mret_req = 0; lsu_busy = 0;
  endtask

  initial begin
    rst = 1; exc_valid = '0; exc_pc = '0; exc_tval = '0; irq_ext = 0; mie = 0;
    mret_req = 0; pc_ex = '0; mtvec_in = 32'h4; mepc_in = '0; lsu_busy = 0;
    m_busy = 0; m_pend = 0; m_irqd = 0; m_tmo = 0; m_mret = 0; m_irq = 0;
    m_acc = 0; m_commit = -1; m_cause = '0; m_mepc = '0; m_mtval = '0;
    #1;
    run(2);
    check_eq("rst_mcause", csr_mcause, 32'd0);
    check_eq("rst_mepc", csr_mepc, 32'd0);
    check_eq("rst_mtval", csr_mtval, 32'd0);
    rst = 0;
    run(2);

    // ecall, LSU idle: minimum latency
    exc_valid = 5'b00010; exc_pc = 32'h100; tick();
    quiet(); run(5);

    // load + store misalign together: load wins
    exc_valid = 5'b11000; exc_pc = 32'h300; exc_tval = 32'h203; tick();
    quiet(); run(5);

    // drain timeout with lsu_busy held for 20 cycles
    exc_valid = 5'b00001; exc_pc = 32'h400; lsu_busy = 1; tick();
    exc_valid = '0; run(19);
    lsu_busy = 0; run(5);
    check_eq("tmo_sticky", 32'(drain_tmo), 32'd1);
    rst = 1; tick(); rst = 0; run(2);

    // interrupt edge while masked, then unmasked; level held gives one trap
    irq_ext = 1; mie = 0; pc_ex = 32'h80; run(5);
    mie = 1; run(25);
    irq_ext = 0; run(3);

    // mret
    mret_req = 1; mepc_in = 32'h240; tick();
    mret_req = 0; run(5);

    // vectored-capable mtvec with an interrupt
    mtvec_in = 32'h1001; irq_ext = 1; run(8);
    irq_ext = 0; mtvec_in = 32'h4; run(2);

    // exception and irq edge in the same cycle: irq taken afterwards
    exc_valid = 5'b00100; exc_pc = 32'h500; irq_ext = 1; tick();
    quiet(); run(10);
    irq_ext = 0; run(2);

    // reset in the middle of a drain aborts the trap
    exc_valid = 5'b00010; lsu_busy = 1; tick();
    exc_valid = '0; run(3);
    rst = 1; tick(); rst = 0; lsu_busy = 0; run(4);

    // random traffic
    begin
      bit sticky_busy = 0;
      for (int i = 0; i < 4000; i++) begin
        if (i % 250 == 0) sticky_busy = ($urandom_range(0, 2) == 0);
        exc_valid = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
        mret_req  = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 14) == 0) irq_ext = ~irq_ext;
        if ($urandom_range(0, 24) == 0) mie = ~mie;
        lsu_busy  = sticky_busy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
        exc_pc    = $urandom; exc_tval = $urandom; pc_ex = $urandom;
        mepc_in   = $urandom; mtvec_in = $urandom;
        rst       = ($urandom_range(0, 699) == 0);
        tick();
      end
      rst = 0; quiet(); run(25);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
